// File: rtl/ring_link_pkg.sv
// Shared definitions for the ring-counter time-multiplexed link (tx mux and rx demux).
package ring_link_pkg;

  localparam int unsigned RING_SLOTS = 3;

  localparam logic [RING_SLOTS-1:0] RING_RESET = 3'b001;
  localparam logic [RING_SLOTS-1:0] SLOT0      = 3'b001;
  localparam logic [RING_SLOTS-1:0] SLOT1      = 3'b010;
  localparam logic [RING_SLOTS-1:0] SLOT2      = 3'b100;

  // True when exactly one of the three ring bits is set.
  function automatic logic is_onehot3(input logic [RING_SLOTS-1:0] r);
    return (r == SLOT0) || (r == SLOT1) || (r == SLOT2);
  endfunction

endpackage

// File: rtl/ring_counter_3.sv
// 3-slot one-hot ring counter with frame restart and recovery from non-one-hot upsets.
module ring_counter_3
  import ring_link_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sync,
  output logic [RING_SLOTS-1:0] ring_o
);

  logic [RING_SLOTS-1:0] ring_q;
  logic [RING_SLOTS-1:0] ring_d;

  // Next slot: illegal state snaps home; sync realigns (a same-cycle strobe counts as slot 0).
  always_comb begin
    ring_d = ring_q;
    if (!is_onehot3(ring_q)) begin
      ring_d = RING_RESET;
    end else if (sync) begin
      ring_d = enable ? SLOT1 : SLOT0;
    end else if (enable) begin
      ring_d = {ring_q[RING_SLOTS-2:0], ring_q[RING_SLOTS-1]};
    end
  end

  // Ring state register.
  always_ff @(posedge clock) begin
    if (reset) ring_q <= RING_RESET;
    else       ring_q <= ring_d;
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/ring_demultiplexer_1x3.sv
// Receive side of the ring link: splits the shared serial line into three held channels,
// updating all three together only when a full slot 0..2 frame has been captured.
module ring_demultiplexer_1x3
  import ring_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sync,
  input  logic [DATA_WIDTH-1:0] serial_in,
  output logic [RING_SLOTS-1:0] ring_counter,
  output logic [DATA_WIDTH-1:0] bit_0,
  output logic [DATA_WIDTH-1:0] bit_1,
  output logic [DATA_WIDTH-1:0] bit_2,
  output logic                  frame_valid
);

  logic [RING_SLOTS-1:0] ring;
  logic                  ring_ok;

  logic [DATA_WIDTH-1:0] cap0_q, cap1_q;
  logic [DATA_WIDTH-1:0] bit0_q, bit1_q, bit2_q;
  logic                  fv_q;

  ring_counter_3 u_ring (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .sync   (sync),
    .ring_o (ring)
  );

  assign ring_ok = is_onehot3(ring);

  // Capture into the slot active before the rotate; slot 2 commits the whole frame.
  // Slot 2 needs no capture reg: it loads the output straight from the line.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap0_q <= '0;
      cap1_q <= '0;
      bit0_q <= '0;
      bit1_q <= '0;
      bit2_q <= '0;
      fv_q   <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      if (ring_ok) begin
        if (sync) begin
          // Partial frame dropped; a same-cycle strobe starts the new frame at slot 0.
          cap0_q <= enable ? serial_in : '0;
          cap1_q <= '0;
        end else if (enable) begin
          unique case (ring)
            SLOT0: cap0_q <= serial_in;
            SLOT1: cap1_q <= serial_in;
            SLOT2: begin
              bit0_q <= cap0_q;
              bit1_q <= cap1_q;
              bit2_q <= serial_in;
              fv_q   <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign ring_counter = ring;
  assign bit_0        = bit0_q;
  assign bit_1        = bit1_q;
  assign bit_2        = bit2_q;
  assign frame_valid  = fv_q;

endmodule

// File: tb/tb_ring_demultiplexer_1x3.sv
// Directed bench for ring_demultiplexer_1x3: reset, full frames, gaps, sync, sync+enable, upset.
module tb_ring_demultiplexer_1x3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sync = 1'b0;
  logic [0:0] serial_in = 1'b0;
  logic [2:0] ring_counter;
  logic [0:0] bit_0, bit_1, bit_2;
  logic       frame_valid;

  int total = 0;
  int bad   = 0;

  ring_demultiplexer_1x3 #(.DATA_WIDTH(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sync         (sync),
    .serial_in    (serial_in),
    .ring_counter (ring_counter),
    .bit_0        (bit_0),
    .bit_1        (bit_1),
    .bit_2        (bit_2),
    .frame_valid  (frame_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_out(input string tag, input logic [2:0] r, input logic fv,
                         input logic b0, input logic b1, input logic b2);
    chk({tag, ".ring"}, 32'(ring_counter), 32'(r));
    chk({tag, ".fv"},   32'(frame_valid),  32'(fv));
    chk({tag, ".bits"}, 32'({bit_2, bit_1, bit_0}), 32'({b2, b1, b0}));
  endtask

  task automatic strobe(input logic v);
    enable = 1'b1; serial_in = v; step();
  endtask

  initial begin
    // Reset held two cycles, then released with enable low
    @(negedge clock);
    step(); step();
    chk_out("reset", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("idle", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back frame 1,0,1
    strobe(1'b1);
    chk_out("f1.s0", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(1'b0);
    chk_out("f1.s1", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(1'b1);
    chk_out("f1.commit", 3'b001, 1'b1, 1'b1, 1'b0, 1'b1);
    enable = 1'b0; step();
    chk_out("f1.after", 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);

    // Gapped frame 0,1,0 with the line toggling between strobes
    strobe(1'b0);
    enable = 1'b0; serial_in = 1'b1; step();
    chk_out("gap.idle1", 3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
    strobe(1'b1);
    enable = 1'b0; serial_in = 1'b0; step();
    chk_out("gap.idle2", 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
    enable = 1'b0; serial_in = 1'b1; step();
    strobe(1'b0);
    chk_out("gap.commit", 3'b001, 1'b1, 1'b0, 1'b1, 1'b0);
    enable = 1'b0; step();

    // sync mid-frame drops the partial 1,1
    strobe(1'b1); strobe(1'b1);
    chk_out("sync.pre", 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
    enable = 1'b0; sync = 1'b1; step();
    chk_out("sync.apply", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
    sync = 1'b0; step();
    chk_out("sync.hold", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
    strobe(1'b0); strobe(1'b0); strobe(1'b0);
    chk_out("sync.f000", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);

    // sync together with enable while in slot 2: strobe becomes slot 0
    strobe(1'b0); strobe(1'b0);
    chk_out("se.pre", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    sync = 1'b1; strobe(1'b1);
    chk_out("se.apply", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    sync = 1'b0;
    strobe(1'b0);
    strobe(1'b1);
    chk_out("se.commit", 3'b001, 1'b1, 1'b1, 1'b0, 1'b1);

    // Upset: non-one-hot ring recovers to slot 0 without capture or commit
    enable = 1'b0;
    force dut.u_ring.ring_q = 3'b110;
    #1 release dut.u_ring.ring_q;
    chk("upset.forced", 32'(ring_counter), 32'h6);
    strobe(1'b0);
    chk_out("upset.recover", 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
    strobe(1'b1); strobe(1'b1); strobe(1'b0);
    chk_out("upset.f110", 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset mid-frame clears outputs and ring
    strobe(1'b1);
    enable = 1'b0; reset = 1'b1; step();
    chk_out("midreset", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
